// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_sync block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO  = 2'd0,
    CHECK_HI = 2'd1,
    IDLE_HI  = 2'd2,
    CHECK_LO = 2'd3
  } db_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; q is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw level through the synchroniser stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronising debouncer: a level is accepted after DB_CYCLES+1 identical samples.
// Optional macro DEBOUNCE_EDGE_EN enables the registered rise/fall pulse outputs.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s;
  db_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          q_q;
  logic          accept_hi;
  logic          accept_lo;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (s)
  );

  // Acceptance happens on the final counted sample of a CHECK state.
  always_comb begin
    accept_hi = 1'b0;
    accept_lo = 1'b0;
    if ((state_q == CHECK_HI) && s && (cnt_q == CNT_LAST)) begin
      accept_hi = 1'b1;
    end else if ((state_q == CHECK_LO) && !s && (cnt_q == CNT_LAST)) begin
      accept_lo = 1'b1;
    end else begin
      accept_hi = 1'b0;
      accept_lo = 1'b0;
    end
  end

  // Debounce FSM with counter and registered level output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_q <= CHECK_HI;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE_LO;
          end
        end
        CHECK_HI: begin
          if (!s) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
          end else if (accept_hi) begin
            state_q <= IDLE_HI;
            q_q     <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_q <= CHECK_LO;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE_HI;
          end
        end
        CHECK_LO: begin
          if (s) begin
            state_q <= IDLE_HI;
            cnt_q   <= '0;
          end else if (accept_lo) begin
            state_q <= IDLE_LO;
            q_q     <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE_LO;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign busy = (state_q == CHECK_HI) || (state_q == CHECK_LO);

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses coincide with the first cycle q shows its new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept_hi;
      fall_q <= accept_lo;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed vector table, corner sequences, and random
// stimulus against a sample-history reference model (DB_CYCLES 4 and 1).
module tb_debounce_sync;

  localparam int SS = 2;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic [1:0] q_o, qb_o, rise_o, fall_o, busy_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(SS), .DB_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .din(din),
    .q(q_o[0]), .qb(qb_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .busy(busy_o[0])
  );

  debounce_sync #(.SYNC_STAGES(SS), .DB_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .din(din),
    .q(q_o[1]), .qb(qb_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .busy(busy_o[1])
  );

  // Reference model: s is din delayed SS edges; q flips once the last
  // DB+1 samples of s all differ from q.
  int   dbv [2];
  logic [7:0]  m_sync [2];
  logic [15:0] m_hist [2];
  int   m_hcnt [2];
  logic m_q [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_busy [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_sync[i] = 8'd0;
        m_hcnt[i] = 0;
        m_q[i]    = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_busy[i] = 1'b0;
      end else begin
        logic s;
        logic acc;
        s = m_sync[i][SS-1];
        m_hist[i] = {m_hist[i][14:0], s};
        if (m_hcnt[i] < 16) m_hcnt[i]++;
        acc = (m_hcnt[i] >= dbv[i] + 1);
        for (int k = 0; k <= dbv[i]; k++) begin
          if (m_hist[i][k] == m_q[i]) acc = 1'b0;
        end
        m_rise[i] = EDGE_EN && acc && !m_q[i];
        m_fall[i] = EDGE_EN && acc && m_q[i];
        m_busy[i] = !acc && (s != m_q[i]);
        if (acc) begin
          m_q[i]    = !m_q[i];
          m_hcnt[i] = 0;
        end
        m_sync[i] = {m_sync[i][6:0], din};
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic step(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    din   = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct packed {
    logic rst;
    logic d;
    logic eq;
    logic eb;
    logic er;
    logic ef;
  } vec_t;

  vec_t tbl [25];

  initial begin
    dbv[0] = 4;
    dbv[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_sync[i] = 8'd0; m_hist[i] = 16'd0; m_hcnt[i] = 0;
      m_q[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0;
    end

    // Row n = state after edge n (row 0 is a reset edge); DB_CYCLES=4.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 1; n <= 8; n++) tbl[n] = '{1'b0, 1'b1, (n >= 7), (n >= 3 && n <= 6), (n == 7), 1'b0};
    for (int n = 9; n <= 16; n++) tbl[n] = '{1'b0, 1'b0, (n < 15), (n >= 11 && n <= 14), 1'b0, (n == 15)};
    for (int n = 17; n <= 24; n++) tbl[n] = '{1'b0, (n <= 19), 1'b0, (n >= 19 && n <= 21), 1'b0, 1'b0};

    for (int n = 0; n < 25; n++) begin
      step(tbl[n].rst, tbl[n].d);
      chk($sformatf("tbl%0d_q", n), q_o[0], tbl[n].eq);
      chk($sformatf("tbl%0d_qb", n), qb_o[0], ~tbl[n].eq);
      chk($sformatf("tbl%0d_busy", n), busy_o[0], tbl[n].eb);
      chk($sformatf("tbl%0d_rise", n), rise_o[0], EDGE_EN && tbl[n].er);
      chk($sformatf("tbl%0d_fall", n), fall_o[0], EDGE_EN && tbl[n].ef);
    end

    // Reset mid-CHECK_HI at cnt=2 aborts; din still high -> rise 7 edges later.
    step(1'b1, 1'b0);
    for (int n = 1; n <= 5; n++) step(1'b0, 1'b1);
    chk("midchk_busy_before", busy_o[0], 1'b1);
    step(1'b1, 1'b1);
    chk("midchk_q", q_o[0], 1'b0);
    chk("midchk_busy", busy_o[0], 1'b0);
    chk("midchk_rise", rise_o[0], 1'b0);
    for (int n = 1; n <= 7; n++) begin
      step(1'b0, 1'b1);
      chk($sformatf("midchk_e%0d_q", n), q_o[0], (n == 7));
      chk($sformatf("midchk_e%0d_rise", n), rise_o[0], EDGE_EN && (n == 7));
      chk($sformatf("db1_e%0d_q", n), q_o[1], (n >= 4));
      chk($sformatf("db1_e%0d_rise", n), rise_o[1], EDGE_EN && (n == 4));
    end

    // DB_CYCLES=1 falling step.
    for (int n = 1; n <= 5; n++) begin
      step(1'b0, 1'b0);
      chk($sformatf("db1_fall_e%0d_q", n), q_o[1], (n < 4));
      chk($sformatf("db1_fall_e%0d_fall", n), fall_o[1], EDGE_EN && (n == 4));
    end

    // Randomised held levels with occasional reset, both configurations.
    begin
      logic lvl;
      int   hold;
      lvl = 1'b0;
      hold = 0;
      for (int t = 0; t < 3000; t++) begin
        if (hold == 0) begin
          lvl  = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 8);
        end
        hold--;
        step(($urandom_range(0, 63) == 0), lvl);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rnd%0d_u%0d_q", t, i), q_o[i], m_q[i]);
          chk($sformatf("rnd%0d_u%0d_qb", t, i), qb_o[i], !m_q[i]);
          chk($sformatf("rnd%0d_u%0d_busy", t, i), busy_o[i], m_busy[i]);
          chk($sformatf("rnd%0d_u%0d_rise", t, i), rise_o[i], m_rise[i]);
          chk($sformatf("rnd%0d_u%0d_fall", t, i), fall_o[i], m_fall[i]);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on din; legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 4, number of CHECK-state cycles the synchronised level must hold before acceptance; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din  input  1  raw asynchronous level (switch/external pin).
REQ-006 q  output  1  registered debounced level, intended to drive a downstream d input.
REQ-007 qb  output  1  combinational complement of q.
REQ-008 rise  output  1  registered one-cycle pulse on accepted 0->1 change of q.
REQ-009 fall  output  1  registered one-cycle pulse on accepted 1->0 change of q.
REQ-010 busy  output  1  high while FSM is in CHECK_HI or CHECK_LO.

Function
REQ-011 din SHALL pass through SYNC_STAGES flops; the last flop output s is the only signal the FSM samples.
REQ-012 FSM states SHALL be IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO; counter cnt width $clog2(DB_CYCLES+1), unsigned, never wraps.
REQ-013 IDLE_LO: s=1 -> CHECK_HI, cnt<=0; s=0 -> stay.
REQ-014 CHECK_HI: s=0 -> IDLE_LO, cnt<=0 (glitch rejected, no pulse); s=1 and cnt<DB_CYCLES-1 -> cnt<=cnt+1; s=1 and cnt==DB_CYCLES-1 -> IDLE_HI, q<=1, cnt<=0.
REQ-015 IDLE_HI / CHECK_LO SHALL mirror REQ-013/014 with polarity inverted; acceptance sets q<=0.
REQ-016 Acceptance SHALL require s stable for DB_CYCLES+1 consecutive samples; q changes on edge SYNC_STAGES+DB_CYCLES+1 counted from the first edge that samples the new din level.
REQ-017 rise (fall) SHALL be high exactly during the cycle in which q first shows 1 (0), and low otherwise; never both high.
REQ-018 q SHALL change only on an acceptance edge; any s toggle inside a CHECK state restarts from the IDLE state with cnt=0.
REQ-019 busy SHALL be registered-state decoded: high iff state is CHECK_HI or CHECK_LO.

Reset
REQ-020 While reset=1 at a rising edge: sync flops<=0, state<=IDLE_LO, cnt<=0, q<=0, rise<=0, fall<=0; hence qb=1, busy=0.
REQ-021 Reset asserted mid-CHECK SHALL abort the check with no rise/fall pulse.
REQ-022 If din is held 1 through reset release, q SHALL rise with a rise pulse exactly SYNC_STAGES+DB_CYCLES+1 edges after the first non-reset edge.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_EN defined: rise/fall generated per REQ-017.
REQ-024 DEBOUNCE_EDGE_EN undefined: rise and fall ports SHALL remain present, tied to 0, no edge registers synthesised; q/qb/busy behaviour unchanged.

Structure
REQ-025 Package debounce_pkg SHALL hold the db_state_t enum (IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO) and the default constants for SYNC_STAGES and DB_CYCLES.
REQ-026 Sub-module sync_chain (parameter STAGES; ports clk, reset, d, q) SHALL implement REQ-011; all other logic in debounce_sync.

Verification (SYNC_STAGES=2, DB_CYCLES=4 unless noted)
REQ-027 din 0->1 before edge 1, held -> q=1, rise=1 after edge 7; rise=0 after edge 8; busy=1 after edges 3-6.
REQ-028 din high for 3 edges then low (glitch) -> q stays 0, rise never asserts, busy returns to 0.
REQ-029 q=1 stable, din 1->0 held -> q=0 and fall=1 after edge 7 relative to sampling edge; qb=1 thereafter.
REQ-030 reset=1 for one edge while in CHECK_HI with cnt=2 -> next cycle q=0, busy=0, no rise; din still 1 -> rise 7 edges later.
REQ-031 DB_CYCLES=1: din step held -> q changes after edge 4; with DEBOUNCE_EDGE_EN undefined, rise/fall remain 0 in all above scenarios.
